// File: rtl/seq_memory_stage.sv
// SEQ Y86-64 memory stage: data-memory read/write with start/done handshake,
// configurable access latency and sticky processor status.
module seq_memory_stage #(
    parameter int MEM_BYTES  = 1024,
    parameter int ACCESS_LAT = 1
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  in_code,
    input  logic [63:0] val_e,
    input  logic [63:0] val_a,
    input  logic [63:0] val_p,
    input  logic        instr_valid,
    input  logic        imem_error,
    output logic        busy,
    output logic        done,
    output logic [63:0] val_m,
    output logic [2:0]  stat,
    output logic        dmem_error
);

    localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam int CW = $clog2(ACCESS_LAT + 1);

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_t;

    state_t          state, next_state;
    stat_t           stat_q, acc_stat, op_stat;
    logic [CW-1:0]   cnt;

    logic            dec_wr, dec_rd, dec_mem, dec_fault;
    logic [63:0]     dec_addr, dec_wdata;

    logic            op_wr, op_rd, op_fault;
    logic [AW-1:0]   op_idx;
    logic [63:0]     op_wdata, rdata;

    logic            accept, finish;

    logic [7:0]      mem [MEM_BYTES];

    // Operation decode and bounds check on the live inputs, used only at acceptance.
    always_comb begin
        dec_wr    = 1'b0;
        dec_rd    = 1'b0;
        dec_addr  = val_e;
        dec_wdata = val_a;
        case (in_code)
            I_RMMOVQ, I_PUSHQ: dec_wr = 1'b1;
            I_CALL: begin
                dec_wr    = 1'b1;
                dec_wdata = val_p;
            end
            I_MRMOVQ: dec_rd = 1'b1;
            I_RET, I_POPQ: begin
                dec_rd   = 1'b1;
                dec_addr = val_a;
            end
            default: ;
        endcase
        dec_mem   = (dec_wr | dec_rd) & instr_valid & ~imem_error;
        dec_fault = dec_mem && (({1'b0, dec_addr} + 65'd8) > 65'(MEM_BYTES));

        if (imem_error || dec_fault)  acc_stat = STAT_ADR;
        else if (!instr_valid)        acc_stat = STAT_INS;
        else if (in_code == I_HALT)   acc_stat = STAT_HLT;
        else                          acc_stat = STAT_AOK;
    end

    // DONE also samples start so back-to-back ops complete every L+1 cycles.
    assign accept = start && (stat_q == STAT_AOK) && (state == S_IDLE || state == S_DONE);
    assign finish = (state == S_WAIT) && (cnt == '0);

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (accept) next_state = S_WAIT;
            S_WAIT:  if (cnt == '0) next_state = S_DONE;
            S_DONE:  next_state = accept ? S_WAIT : S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    assign busy = (state == S_WAIT);
    assign done = (state == S_DONE);
    assign stat = stat_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            op_wr      <= 1'b0;
            op_rd      <= 1'b0;
            op_fault   <= 1'b0;
            op_idx     <= '0;
            op_wdata   <= '0;
            op_stat    <= STAT_AOK;
            val_m      <= '0;
            stat_q     <= STAT_AOK;
            dmem_error <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                op_wr    <= dec_wr & dec_mem;
                op_rd    <= dec_rd & dec_mem;
                op_fault <= dec_fault;
                op_idx   <= dec_addr[AW-1:0];
                op_wdata <= dec_wdata;
                op_stat  <= acc_stat;
                cnt      <= (dec_mem && !dec_fault) ? CW'(ACCESS_LAT - 1) : '0;
            end else if (state == S_WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (finish) begin
                dmem_error <= op_fault;
                if (stat_q == STAT_AOK) stat_q <= op_stat;
                if (op_rd && !op_fault) val_m <= rdata;
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int unsigned i = 0; i < 8; i++)
            rdata[8*i +: 8] = mem[op_idx + AW'(i)];
    end

    // Storage is not reset; an aborted access never reaches finish, so nothing is written.
    always_ff @(posedge clock) begin
        if (finish && op_wr && !op_fault) begin
            for (int unsigned i = 0; i < 8; i++)
                mem[op_idx + AW'(i)] <= op_wdata[8*i +: 8];
        end
    end

endmodule
